// File: rtl/regfile_wr_arbiter.sv
// Round-robin arbiter sharing the single register-file write port among NREQ write-back sources.
// Optional per-source commit counters (wr_cnt output) are enabled by defining RFA_WRCNT_EN.
module regfile_wr_arbiter #(
  parameter int NREQ = 3,
  parameter int AW   = 5,
  parameter int DW   = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [NREQ*AW-1:0]   req_addr,
  input  logic [NREQ*DW-1:0]   req_data,
  input  logic                 rf_hold,
  output logic                 rf_wren,
  output logic [AW-1:0]        rf_wr_addrd,
  output logic [DW-1:0]        rf_wr_data,
`ifdef RFA_WRCNT_EN
  output logic [NREQ*16-1:0]   wr_cnt,
`endif
  output logic                 arb_busy
);

  localparam int PW = $clog2(NREQ);
  localparam logic [PW:0]   NREQ_W = (PW+1)'(NREQ);
  localparam logic [PW-1:0] LAST_IDX = PW'(NREQ-1);

  logic [AW-1:0] addr_arr [NREQ];
  logic [DW-1:0] data_arr [NREQ];

  genvar gi;
  generate
    for (gi = 0; gi < NREQ; gi++) begin : g_unpack
      assign addr_arr[gi] = req_addr[gi*AW +: AW];
      assign data_arr[gi] = req_data[gi*DW +: DW];
    end
  endgenerate

  logic          out_valid_q, out_valid_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] data_q, data_d;
  logic [PW-1:0] rr_ptr_q, rr_ptr_d;
`ifdef RFA_WRCNT_EN
  logic [PW-1:0] src_q, src_d;
`endif

  logic          accept;
  logic          grant_any;
  logic [PW-1:0] grant_idx;
  logic          xfer;
  logic [AW-1:0] sel_addr;
  logic [DW-1:0] sel_data;

  assign accept = !out_valid_q || !rf_hold;

  // Scan starting at rr_ptr, wrapping at NREQ-1; first pending requester wins.
  always_comb begin
    logic [PW:0] cand;
    grant_any = 1'b0;
    grant_idx = '0;
    cand      = '0;
    for (int k = 0; k < NREQ; k++) begin
      cand = {1'b0, rr_ptr_q} + (PW+1)'(k);
      if (cand >= NREQ_W) cand = cand - NREQ_W;
      if (!grant_any && req_valid[cand[PW-1:0]]) begin
        grant_any = 1'b1;
        grant_idx = cand[PW-1:0];
      end
    end
  end

  assign xfer     = grant_any && accept;
  assign sel_addr = addr_arr[grant_idx];
  assign sel_data = data_arr[grant_idx];

  // Ready stays low while reset is asserted even though the output register is empty.
  always_comb begin
    req_ready = '0;
    if (xfer && rst_n) req_ready[grant_idx] = 1'b1;
  end

  always_comb begin
    out_valid_d = out_valid_q;
    addr_d      = addr_q;
    data_d      = data_q;
    rr_ptr_d    = rr_ptr_q;
`ifdef RFA_WRCNT_EN
    src_d       = src_q;
`endif
    if (xfer) begin
      rr_ptr_d = (grant_idx == LAST_IDX) ? '0 : grant_idx + 1'b1;
      // A transfer implies the previous entry is empty or draining this cycle.
      if (sel_addr != '0) begin
        out_valid_d = 1'b1;
        addr_d      = sel_addr;
        data_d      = sel_data;
`ifdef RFA_WRCNT_EN
        src_d       = grant_idx;
`endif
      end else begin
        out_valid_d = 1'b0;
      end
    end else if (!rf_hold) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      addr_q      <= '0;
      data_q      <= '0;
      rr_ptr_q    <= '0;
`ifdef RFA_WRCNT_EN
      src_q       <= '0;
`endif
    end else begin
      out_valid_q <= out_valid_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      rr_ptr_q    <= rr_ptr_d;
`ifdef RFA_WRCNT_EN
      src_q       <= src_d;
`endif
    end
  end

  assign rf_wren     = out_valid_q && !rf_hold;
  assign rf_wr_addrd = addr_q;
  assign rf_wr_data  = data_q;
  assign arb_busy    = out_valid_q;

`ifdef RFA_WRCNT_EN
  logic [15:0] cnt_q [NREQ];

  generate
    for (gi = 0; gi < NREQ; gi++) begin : g_cnt
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          cnt_q[gi] <= '0;
        end else if (rf_wren && (src_q == PW'(gi)) && (cnt_q[gi] != 16'hFFFF)) begin
          cnt_q[gi] <= cnt_q[gi] + 16'd1;
        end
      end
      assign wr_cnt[gi*16 +: 16] = cnt_q[gi];
    end
  endgenerate
`endif

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// Scoreboard bench for regfile_wr_arbiter: a transaction-level model predicts grants and
// queues expected writes; an independent monitor pops them whenever rf_wren is seen.
module tb_regfile_wr_arbiter;
  localparam int NREQ = 3;
  localparam int AW   = 5;
  localparam int DW   = 32;

  typedef struct packed {
    logic [2:0]    src;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } ent_t;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic [NREQ-1:0]      req_valid = '0;
  logic [NREQ-1:0]      req_ready;
  logic [NREQ*AW-1:0]   req_addr = '0;
  logic [NREQ*DW-1:0]   req_data = '0;
  logic                 rf_hold = 1'b0;
  logic                 rf_wren;
  logic [AW-1:0]        rf_wr_addrd;
  logic [DW-1:0]        rf_wr_data;
  logic                 arb_busy;
`ifdef RFA_WRCNT_EN
  logic [NREQ*16-1:0]   wr_cnt;
`endif

  regfile_wr_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW)) dut (
    .clk(clk),
    .rst_n(rst_n),
`ifdef RFA_WRCNT_EN
    .wr_cnt(wr_cnt),
`endif
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_addr(req_addr),
    .req_data(req_data),
    .rf_hold(rf_hold),
    .rf_wren(rf_wren),
    .rf_wr_addrd(rf_wr_addrd),
    .rf_wr_data(rf_wr_data),
    .arb_busy(arb_busy)
  );

  always #5 clk = ~clk;

  int nchk = 0;
  int nfail = 0;

  ent_t rq [NREQ][$];
  ent_t exp_q [$];
  int   m_rr = 0;
  bit   m_busy = 0;
  int   m_cnt [NREQ];

  logic [NREQ-1:0] s_ready;
  logic            s_wren, s_busy;
  logic [AW-1:0]   s_addr;
  int              s_grant;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    nchk++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push(input int src, input logic [AW-1:0] a, input logic [DW-1:0] d);
    ent_t e;
    e.src = 3'(src);
    e.a = a;
    e.d = d;
    rq[src].push_back(e);
  endtask

  task automatic drive_inputs();
    for (int i = 0; i < NREQ; i++) begin
      if (rq[i].size() > 0) begin
        req_valid[i] = 1'b1;
        req_addr[i*AW +: AW] = rq[i][0].a;
        req_data[i*DW +: DW] = rq[i][0].d;
      end else begin
        req_valid[i] = 1'b0;
        req_addr[i*AW +: AW] = AW'($urandom);
        req_data[i*DW +: DW] = $urandom;
      end
    end
  endtask

  // One clock cycle: entered and left at posedge+1.
  task automatic cycle(input logic hold);
    bit acc;
    int win;
    logic [NREQ-1:0] exp_ready;
    ent_t e;
    rf_hold = hold;
    drive_inputs();
    @(negedge clk);
    s_ready = req_ready;
    s_wren  = rf_wren;
    s_busy  = arb_busy;
    s_addr  = rf_wr_addrd;
    s_grant = -1;
    for (int i = 0; i < NREQ; i++) if (s_ready[i]) s_grant = i;
    acc = !m_busy || !hold;
    win = -1;
    for (int k = 0; k < NREQ; k++) begin
      int idx;
      idx = (m_rr + k) % NREQ;
      if (win < 0 && rq[idx].size() > 0) win = idx;
    end
    exp_ready = '0;
    if (acc && win >= 0) exp_ready[win] = 1'b1;
    chk("req_ready", 64'(s_ready), 64'(exp_ready));
    chk("rf_wren", 64'(s_wren), 64'(m_busy && !hold));
    chk("arb_busy", 64'(s_busy), 64'(m_busy));
    if (acc && win >= 0) begin
      e = rq[win].pop_front();
      m_rr = (win + 1) % NREQ;
      if (e.a != '0) begin
        exp_q.push_back(e);
        m_busy = 1;
      end else begin
        m_busy = 0;
      end
    end else if (!hold) begin
      m_busy = 0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    m_rr = 0;
    m_busy = 0;
    exp_q.delete();
    for (int i = 0; i < NREQ; i++) m_cnt[i] = 0;
  endtask

  // Asynchronous reset mid-cycle; requesters keep their valid asserted throughout.
  task automatic do_reset();
    drive_inputs();
    #2 rst_n = 1'b0;
    #1;
    chk("rst_wren", 64'(rf_wren), 64'(0));
    chk("rst_busy", 64'(arb_busy), 64'(0));
    chk("rst_addr", 64'(rf_wr_addrd), 64'(0));
    chk("rst_data", 64'(rf_wr_data), 64'(0));
    chk("rst_ready", 64'(req_ready), 64'(0));
    model_reset();
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while ((rq[0].size() + rq[1].size() + rq[2].size() > 0 || m_busy) && n < budget) begin
      cycle(1'b0);
      n++;
    end
    chk("drain_budget", 64'(n < budget), 64'(1));
  endtask

  // Monitor: every committed write must match the oldest outstanding expectation.
  initial begin
    ent_t e;
    forever begin
      @(negedge clk);
      #1;
      if (rf_wren === 1'b1) begin
        if (exp_q.size() == 0) begin
          nchk++;
          nfail++;
          $display("FAIL sb_unexpected: got write addr %0h data %0h expected none", rf_wr_addrd, rf_wr_data);
        end else begin
          e = exp_q.pop_front();
          chk("sb_addr", 64'(rf_wr_addrd), 64'(e.a));
          chk("sb_data", 64'(rf_wr_data), 64'(e.d));
          if (m_cnt[e.src] < 16'hFFFF) m_cnt[e.src]++;
          $display("write src=%0d addr=%0d data=%08h", e.src, rf_wr_addrd, rf_wr_data);
        end
      end
    end
  end

  initial begin
    model_reset();
    #3;
    chk("por_wren", 64'(rf_wren), 64'(0));
    chk("por_busy", 64'(arb_busy), 64'(0));
    chk("por_ready", 64'(req_ready), 64'(0));
    chk("por_addr", 64'(rf_wr_addrd), 64'(0));
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Single request
    push(0, 5'd5, 32'hDEAD_BEEF);
    cycle(1'b0);
    chk("single_ready", 64'(s_ready), 64'(3'b001));
    cycle(1'b0);
    chk("single_wren", 64'(s_wren), 64'(1));
    chk("single_addr", 64'(s_addr), 64'(5));
    cycle(1'b0);
    chk("single_idle", 64'(s_wren), 64'(0));

    // Round-robin fairness from a fresh pointer
    do_reset();
    for (int r = 0; r < 2; r++)
      for (int i = 0; i < NREQ; i++) push(i, 5'(i + 1), $urandom);
    for (int c = 0; c < 6; c++) begin
      cycle(1'b0);
      chk("rr_grant", 64'(s_grant), 64'(c % 3));
      if (c >= 1) chk("rr_wren", 64'(s_wren), 64'(1));
    end
    cycle(1'b0);
    chk("rr_last_wren", 64'(s_wren), 64'(1));

    // Hold
    push(0, 5'd7, 32'h0000_0077);
    cycle(1'b0);
    push(1, 5'd11, 32'h0000_0011);
    for (int c = 0; c < 3; c++) begin
      cycle(1'b1);
      chk("hold_wren", 64'(s_wren), 64'(0));
      chk("hold_ready", 64'(s_ready), 64'(0));
      chk("hold_addr", 64'(s_addr), 64'(7));
    end
    cycle(1'b0);
    chk("rel_wren", 64'(s_wren), 64'(1));
    chk("rel_addr", 64'(s_addr), 64'(7));
    chk("rel_ready", 64'(s_ready), 64'(3'b010));
    cycle(1'b0);
    chk("rel_next_addr", 64'(s_addr), 64'(11));

    // x0 drop, pointer wraps to 0
    push(2, 5'd0, 32'h0000_1234);
    cycle(1'b0);
    chk("x0_ready", 64'(s_ready), 64'(3'b100));
    push(0, 5'd20, $urandom);
    push(1, 5'd21, $urandom);
    cycle(1'b0);
    chk("x0_wren", 64'(s_wren), 64'(0));
    chk("x0_busy", 64'(s_busy), 64'(0));
    chk("x0_wrap_grant", 64'(s_grant), 64'(0));
    drain(10);

    // Reset mid-operation with addr 9 pending
    push(0, 5'd9, 32'h0000_0009);
    cycle(1'b0);
    push(1, 5'd13, 32'h0000_0013);
    rf_hold = 1'b1;
    do_reset();
    cycle(1'b0);
    chk("postrst_grant", 64'(s_grant), 64'(1));
    cycle(1'b0);
    chk("postrst_addr", 64'(s_addr), 64'(13));
    drain(10);

    // Randomized traffic
    for (int c = 0; c < 400; c++) begin
      if ($urandom_range(0, 99) < 60) begin
        int src;
        logic [AW-1:0] a;
        src = $urandom_range(0, NREQ - 1);
        a = ($urandom_range(0, 9) == 0) ? '0 : AW'($urandom_range(1, 31));
        push(src, a, $urandom);
      end
      cycle(($urandom_range(0, 3) == 0) ? 1'b1 : 1'b0);
    end
    drain(400);

`ifdef RFA_WRCNT_EN
    begin
      for (int i = 0; i < NREQ; i++)
        chk("cnt_model", 64'(wr_cnt[i*16 +: 16]), 64'(m_cnt[i]));
      do_reset();
      for (int i = 0; i < NREQ; i++) chk("cnt_rst", 64'(wr_cnt[i*16 +: 16]), 64'(0));
      for (int i = 0; i < 70000; i++) push(0, 5'd1 + 5'(i % 30), 32'(i));
      for (int i = 0; i < 3; i++) push(1, 5'd17, 32'(i));
      push(2, 5'd0, 32'h0);
      drain(70100);
      cycle(1'b0);
      chk("cnt_alu_sat", 64'(wr_cnt[15:0]), 64'(16'hFFFF));
      chk("cnt_load", 64'(wr_cnt[31:16]), 64'(3));
      chk("cnt_muldiv", 64'(wr_cnt[47:32]), 64'(0));
    end
`endif

    cycle(1'b0);
    chk("sb_empty", 64'(exp_q.size()), 64'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end

endmodule

// File: doc/regfile_wr_arbiter.md
Name: regfile_wr_arbiter

Overview:
- Shares the single register-file write port between NREQ write-back sources: ALU result, load data and multi-cycle mul/div result.
- Uses round-robin arbitration and a per-requester valid/ready handshake.
- Has a one-entry output register that drives the register file's wren / wr_addrd / wr_data directly.
- Sits between the execute/memory stages and the register file. Supports a hold input so the write port can be frozen.

Parameters:
- NREQ, 3, number of write-back requesters. Index 0 = ALU, 1 = LOAD, 2 = MULDIV. Legal range 2..8.
- AW, 5, register address width.
- DW, 32, register data width.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req_valid  input  NREQ  bit i: requester i has a write pending.
- req_ready  output  NREQ  bit i: requester i's write is accepted this cycle.
- req_addr  input  NREQ*AW  requester i's address in bits [i*AW +: AW].
- req_data  input  NREQ*DW  requester i's data in bits [i*DW +: DW].
- rf_hold  input  1  freezes the write port; the pending write is kept.
- rf_wren  output  1  register-file write enable.
- rf_wr_addrd  output  AW  register-file write address.
- rf_wr_data  output  DW  register-file write data.
- arb_busy  output  1  high while the output register holds a write not yet committed.

Behaviour:
- Reset (asynchronous, rst_n low):
  - out_valid = 0, rf_wr_addrd = 0, rf_wr_data = 0, rr_ptr = 0.
  - rf_wren = 0, arb_busy = 0, req_ready = 0.
  - Reset mid-operation discards any pending output write. Requesters keep their valid asserted and are re-arbitrated from rr_ptr = 0.
- accept = !out_valid || !rf_hold.
- Grant is combinational:
  - Search req_valid starting at rr_ptr, increasing index, wrapping at NREQ-1 back to 0.
  - The first set bit wins.
  - req_ready is one-hot for the winner, gated by accept. It is all-zero when there are no requests or accept = 0.
- Transfer: req_valid[i] && req_ready[i]. At most one transfer per cycle.
- rr_ptr update:
  - On a transfer from i, rr_ptr <= (i == NREQ-1) ? 0 : i+1.
  - Otherwise rr_ptr is unchanged.
- Output register, updated at the clock edge:
  - Transfer with addr != 0: load addr/data, out_valid <= 1.
  - Transfer with addr == 0: write is dropped. It still counts as a grant and still advances rr_ptr. out_valid <= 0 if the previous entry drained, else the entry is held.
  - No transfer and !rf_hold: out_valid <= 0. Address/data registers keep their last values.
  - rf_hold = 1: output register unchanged.
- Output timing:
  - rf_wren = out_valid && !rf_hold.
  - arb_busy = out_valid.
  - Latency: a request accepted in cycle N produces rf_wren in cycle N+1 if rf_hold is low.
  - With continuous requests and rf_hold low, throughput is one write per cycle.
- Simultaneous drain and load (out_valid = 1, rf_hold = 0, transfer): the old entry is written to the register file this cycle and the new entry is loaded at the edge.
- Requester rule: req_valid/addr/data must stay stable until req_ready. Ready never depends on the requester's own data.
- Ordering: writes from one requester commit in acceptance order. No ordering is guaranteed between different requesters.

Optional Feature:
- Macro: RFA_WRCNT_EN.
- Defined:
  - Adds output port wr_cnt, width NREQ*16. Field i in bits [i*16 +: 16] counts requester i's writes committed to the register file (rf_wren cycles), attributed to the source index stored with the entry.
  - Counters saturate at 16'hFFFF and are cleared to 0 by reset.
  - Dropped x0 writes are not counted.
- Undefined: the port, the counters and the stored source index are absent. Behaviour is otherwise identical.

Test Plan:
- Reset / single request:
  - Reset, then req_valid = 3'b001, addr 5, data 32'hDEAD_BEEF for one handshake.
  - req_ready[0] = 1 in cycle N. In N+1: rf_wren = 1, rf_wr_addrd = 5, rf_wr_data = DEAD_BEEF. rf_wren = 0 in N+2.
- Round-robin fairness: all three requesters hold valid continuously with distinct addresses 1/2/3. Grants go 0,1,2,0,1,2. rf_wren is high every cycle from the second cycle on.
- Hold:
  - Write to addr 7 accepted, then rf_hold = 1 for 3 cycles while req 1 is valid.
  - rf_wren = 0 and req_ready = 0 during the hold, with addr 7 retained.
  - On release: addr 7 is written, req 1 is accepted the same cycle and written the next cycle.
- x0 drop:
  - req 2 writes addr 0, data 32'h1234.
  - req_ready[2] = 1, rf_wren stays 0, arb_busy stays 0, rr_ptr wraps to 0 (req 0 wins the next contention).
- Reset mid-operation:
  - rst_n asserted while out_valid = 1 with addr 9.
  - Outputs go 0 asynchronously. After release, no write to addr 9 occurs unless it is re-requested.
- RFA_WRCNT_EN:
  - 70000 back-to-back ALU writes and 3 LOAD writes.
  - wr_cnt[15:0] = 16'hFFFF (saturated), wr_cnt[31:16] = 3, wr_cnt[47:32] = 0.
